// File: rtl/imm_encoder.sv
// RISC-V I/S/B instruction encoder feeding a DEPTH-entry output FIFO with a saturating error counter.
// Define IMM_ENCODER_RANGE_CHECK_EN to also flag immediates that do not fit their format.
module imm_encoder #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic [63:0]      in_imm,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;

   logic [31:0] enc_inst;
   logic        enc_err;
   logic        imm_bad;

   // ---------------------------------------------------------------
   // Combinational encode of the presented request
   // ---------------------------------------------------------------
   always_comb begin
      enc_inst = 32'h0;
      enc_err  = 1'b0;
      unique case (in_op)
         OP_LOAD, OP_IMM: begin
            enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op, 2'b11};
         end
         OP_STORE: begin
            enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op, 2'b11};
         end
         OP_BRANCH: begin
            enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_op, 2'b11};
         end
         default: begin
            enc_inst = 32'h0;
            enc_err  = 1'b1;
         end
      endcase
      enc_err = enc_err | imm_bad;
   end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
   logic signed [63:0] simm;
   logic               is_oor;
   logic               b_oor;

   assign simm   = $signed(in_imm);
   assign is_oor = (simm < -64'sd2048) || (simm > 64'sd2047);
   assign b_oor  = (simm < -64'sd4096) || (simm > 64'sd4094) || in_imm[0];

   always_comb begin
      imm_bad = 1'b0;
      if (in_op == OP_LOAD || in_op == OP_IMM || in_op == OP_STORE)
         imm_bad = is_oor;
      else if (in_op == OP_BRANCH)
         imm_bad = b_oor;
   end
`else
   assign imm_bad = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------
   logic [31:0]   mem_inst [DEPTH];
   logic          mem_err  [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [31:0]   last_inst;
   logic          last_err;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign in_ready  = !rst && (!full || pop);
   assign push      = in_valid && in_ready;

   // Empty FIFO shows the last popped entry rather than stale slot contents.
   assign out_inst = empty ? last_inst : mem_inst[rd_ptr];
   assign out_err  = empty ? last_err  : mem_err[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wr_ptr] <= enc_inst;
         mem_err[wr_ptr]  <= enc_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_inst <= 32'h0;
         last_err  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            last_inst <= mem_inst[rd_ptr];
            last_err  <= mem_err[rd_ptr];
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Saturating count of bad entries accepted
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (push && enc_err && (err_count != '1))
         err_count <= err_count + 1'b1;
   end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2: output-buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 16: width of the error counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-007 SHALL have port in_op  input  5  opcode[6:2]: 00000 load (I), 00100 op-imm (I), 01000 store (S), 11000 branch (B).
REQ-008 SHALL have port in_imm  input  64  signed immediate; byte offset for B.
REQ-009 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each, and in_funct3  input  3  register and funct3 fields.
REQ-010 SHALL have port out_valid  output  1  buffer head valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes head when high with out_valid.
REQ-012 SHALL have port out_inst  output  32  encoded instruction, bit 31 = MSB.
REQ-013 SHALL have port out_err  output  1  head entry flagged bad.
REQ-014 SHALL have port err_count  output  CNT_W  saturating count of flagged entries accepted.

Function
- REQ-015 SHALL set opcode bits [6:0] to {in_op, 2'b11} for every legal in_op.
- REQ-016 I-type SHALL place the fields as: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd; rs2 is ignored.
- REQ-017 S-type SHALL place the fields as: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0]; rd is ignored.
- REQ-018 B-type SHALL place the fields as: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11]; rd is ignored.
- REQ-019 An illegal in_op SHALL produce out_inst=32'h0 and out_err=1.
- REQ-020 Encoding SHALL be registered into a DEPTH-entry FIFO on acceptance; out_inst, out_err and out_valid SHALL be driven from the FIFO head.
- REQ-021 Latency: a request accepted in cycle N into an empty FIFO SHALL show out_valid=1 in cycle N+1.
- REQ-022 in_ready SHALL be 1 when the FIFO is not full, and SHALL also be 1 when the FIFO is full and out_ready=1 with out_valid=1 (simultaneous pop and push).
- REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
- REQ-024 When the FIFO is empty, out_valid SHALL be 0 and out_inst/out_err SHALL hold the last popped values (0 after reset).
- REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
- REQ-026 The head SHALL remain stable while out_valid=1 and out_ready=0.
- REQ-027 err_count SHALL increment by 1 per accepted request whose out_err is 1, and SHALL saturate at all ones.

Reset
- REQ-028 On rst=1 at a clock edge: FIFO emptied, pointers 0, out_valid=0, out_inst=0, out_err=0, err_count=0, in_ready=0 during the reset cycle.
- REQ-029 A reset mid-stream SHALL discard all buffered entries; a request presented in the reset cycle SHALL NOT be accepted.

Configuration
- REQ-030 With IMM_ENCODER_RANGE_CHECK_EN defined, out_err SHALL additionally be set in three cases: an I/S immediate outside -2048..2047; a B immediate outside -4096..4094; a B immediate with bit 0 set. The instruction bits are still truncated-encoded.
- REQ-031 Without IMM_ENCODER_RANGE_CHECK_EN, immediates SHALL be silently truncated, and out_err SHALL reflect only illegal in_op.

Verification
- V1 Reset, then accept op=00100, imm=-1, rs1=2, rd=1, f3=0 → next cycle out_valid=1, out_inst=32'hFFF10093, out_err=0.
- V2 op=01000, imm=0x7FF, rs2=5, rs1=6, f3=3 → out_inst=32'h7E533FA3.
- V3 op=11000, imm=-4096, rs1=rs2=0, f3=0 → out_inst=32'h80000063; with the macro, imm=3 → out_err=1 and err_count=1.
- V4 Hold out_ready=0, offer 3 requests → 2 accepted, in_ready=0 on the third until out_ready=1; order preserved; with full FIFO and out_ready=1, push and pop occur in the same cycle.
- V5 op=10101 → out_inst=0, out_err=1; preload err_count to all ones via 65535 bad requests, send 1 more → err_count stays 16'hFFFF.
- V6 Fill FIFO, assert rst for one cycle with in_valid=1 → out_valid=0, err_count=0, nothing accepted.
